// File: rtl/uart_out_buffer.sv
// uart_out_buffer: buffers core OUT bytes in a FIFO and sends them as 8N1 UART frames, LSB first
// Ports:
//   clk        - clock
//   rstn       - synchronous active-low reset
//   out_req    - core output request; one byte per high pulse, however long
//   out_data   - core output word; only [7:0] is transmitted
//   out_busy   - FIFO full; the core stalls OUT while high
//   txd        - UART serial output, idles high
//   fifo_count - current FIFO occupancy (debug)
module uart_out_buffer #(
    parameter int CLK_PER_BIT    = 868,
    parameter int FIFO_DEPTH_LOG = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    out_req,
    input  logic [31:0]             out_data,
    output logic                    out_busy,
    output logic                    txd,
    output logic [FIFO_DEPTH_LOG:0] fifo_count
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] CYC_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [FIFO_DEPTH_LOG:0] FULL_COUNT = (FIFO_DEPTH_LOG + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]                r_mem [DEPTH];
    logic [FIFO_DEPTH_LOG-1:0] r_wptr;
    logic [FIFO_DEPTH_LOG-1:0] r_rptr;
    logic [FIFO_DEPTH_LOG:0]   r_count;
    logic                      r_armed;
    state_t                    r_state;
    logic [CW-1:0]             r_cyc;
    logic [2:0]                r_bit;
    logic [7:0]                r_shift;
    logic                      r_txd;
    logic                      w_full;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_cyc_done;
    logic                      w_unused;

    assign w_full     = r_count == FULL_COUNT;
    // one byte per request pulse: r_armed drops on accept and re-arms once out_req goes low
    assign w_push     = out_req & r_armed & ~w_full;
    assign w_pop      = (r_state == IDLE) && (r_count != '0);
    assign w_cyc_done = r_cyc == CYC_LAST;
    assign w_unused   = ^out_data[31:8];

    assign out_busy   = w_full;
    assign fifo_count = r_count;
    assign txd        = r_txd;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= out_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_armed <= 1'b1;
        end else begin
            if (w_push) r_wptr <= r_wptr + FIFO_DEPTH_LOG'(1);
            if (w_pop) r_rptr <= r_rptr + FIFO_DEPTH_LOG'(1);
            r_count <= r_count + (FIFO_DEPTH_LOG + 1)'(w_push) - (FIFO_DEPTH_LOG + 1)'(w_pop);
            r_armed <= ~out_req | (r_armed & ~w_push);
        end
    end

    // txd is loaded together with each state change so the line never glitches
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cyc   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_txd <= ~w_pop;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
                        r_state <= START;
                        r_cyc   <= '0;
                    end
                end
                START: begin
                    r_cyc <= w_cyc_done ? '0 : r_cyc + CW'(1);
                    if (w_cyc_done) begin
                        r_state <= DATA;
                        r_bit   <= '0;
                        r_txd   <= r_shift[0];
                    end
                end
                DATA: begin
                    r_cyc <= w_cyc_done ? '0 : r_cyc + CW'(1);
                    if (w_cyc_done && r_bit == 3'd7) begin
                        r_state <= STOP;
                        r_txd   <= 1'b1;
                    end else if (w_cyc_done) begin
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + 3'd1;
                        r_txd   <= r_shift[1];
                    end
                end
                STOP: begin
                    r_cyc <= w_cyc_done ? '0 : r_cyc + CW'(1);
                    r_txd <= 1'b1;
                    if (w_cyc_done) r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_out_buffer.sv
// tb_uart_out_buffer: directed, table-driven and random checks of uart_out_buffer against a frame-level model
module tb_uart_out_buffer;
    localparam int CPB   = 4;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int FR    = 10 * CPB;
    localparam int LOGN  = 16384;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        out_req = 1'b0;
    logic [31:0] out_data = '0;
    logic        out_busy;
    logic        txd;
    logic [DL:0] fifo_count;

    always #5 clk = ~clk;

    uart_out_buffer #(.CLK_PER_BIT(CPB), .FIFO_DEPTH_LOG(DL)) dut (
        .clk(clk), .rstn(rstn), .out_req(out_req), .out_data(out_data),
        .out_busy(out_busy), .txd(txd), .fifo_count(fifo_count)
    );

    int checks = 0;
    int errors = 0;

    byte unsigned q[$];
    bit           m_armed = 1'b1;
    bit           m_active = 1'b0;
    int           m_edge = 0;
    int           m_pop = 0;
    byte unsigned m_cur = 0;
    bit           m_acc = 1'b0;
    int           acc_cycle = 0;
    int           peak = 0;
    logic         tx_log [LOGN];
    byte unsigned dq[$];
    int           ds[$];

    typedef struct {
        logic        rstn;
        logic        req;
        logic [31:0] data;
        logic        busy;
        int          cnt;
        logic        txd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, m_edge, act, exp);
        end
    endtask

    // expected line level from the position inside the current frame
    function automatic logic exp_txd();
        int seg;
        if (!m_active || (m_edge - m_pop) >= FR) return 1'b1;
        seg = (m_edge - m_pop) / CPB;
        if (seg == 0) return 1'b0;
        if (seg == 9) return 1'b1;
        return m_cur[seg-1];
    endfunction

    // one clock: drive inputs, advance the model at the edge, compare 1 time unit later
    task automatic cyc(input logic r, input logic rq, input logic [31:0] d);
        int pre;
        bit tx_free;
        rstn = r;
        out_req = rq;
        out_data = d;
        @(posedge clk);
        m_edge++;
        m_acc = 1'b0;
        if (!r) begin
            q.delete();
            m_armed = 1'b1;
            m_active = 1'b0;
        end else begin
            pre = q.size();
            tx_free = !m_active || (m_edge - m_pop > FR);
            if (tx_free && pre > 0) begin
                m_cur = q.pop_front();
                m_pop = m_edge;
                m_active = 1'b1;
            end
            m_acc = rq && m_armed && (pre != DEPTH);
            if (m_acc) begin
                q.push_back(d[7:0]);
                acc_cycle = m_edge - 1;
            end
            m_armed = !rq || (m_armed && !m_acc);
        end
        #1;
        if (m_edge < LOGN) tx_log[m_edge] = txd;
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
        chk("model_txd", txd, exp_txd());
        chk("model_count", fifo_count, q.size());
        chk("model_busy", out_busy, q.size() == DEPTH);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'h0);
    endtask

    task automatic pulse(input logic [31:0] d);
        cyc(1'b1, 1'b1, d);
        cyc(1'b1, 1'b0, 32'h0);
    endtask

    // recover bytes and start cycles from the recorded line by mid-bit sampling
    task automatic decode(input int lo, input int hi);
        int i;
        byte unsigned b;
        dq.delete();
        ds.delete();
        i = lo + 1;
        while (i <= hi && i + FR < LOGN) begin
            if (tx_log[i-1] === 1'b1 && tx_log[i] === 1'b0) begin
                b = 0;
                for (int k = 0; k < 8; k++) b[k] = tx_log[i + CPB * (k + 1) + CPB / 2];
                dq.push_back(b);
                ds.push_back(i);
                i += FR;
            end else begin
                i++;
            end
        end
    endtask

    initial begin
        vec_t tv[8];
        int t0;
        int n;
        tv[0] = '{1'b0, 1'b0, 32'h0,  1'b0, 0, 1'b1};
        tv[1] = '{1'b0, 1'b1, 32'h41, 1'b0, 0, 1'b1};
        tv[2] = '{1'b1, 1'b1, 32'h41, 1'b0, 1, 1'b1};
        tv[3] = '{1'b1, 1'b0, 32'h0,  1'b0, 0, 1'b0};
        tv[4] = '{1'b1, 1'b0, 32'h0,  1'b0, 0, 1'b0};
        tv[5] = '{1'b1, 1'b0, 32'h0,  1'b0, 0, 1'b0};
        tv[6] = '{1'b1, 1'b0, 32'h0,  1'b0, 0, 1'b0};
        tv[7] = '{1'b1, 1'b0, 32'h0,  1'b0, 0, 1'b1};

        t0 = 0;
        tx_log[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(tv[i].rstn, tv[i].req, tv[i].data);
            chk($sformatf("tv%0d_busy", i), out_busy, tv[i].busy);
            chk($sformatf("tv%0d_count", i), fifo_count, tv[i].cnt);
            chk($sformatf("tv%0d_txd", i), txd, tv[i].txd);
        end
        idle(FR);
        decode(t0, m_edge);
        chk("t1_frames", dq.size(), 1);
        if (dq.size() >= 1) begin
            chk("t1_byte", dq[0], 8'h41);
            chk("t1_start_latency", ds[0] - 2, 2);
        end
        chk("t1_count_end", fifo_count, 0);

        t0 = m_edge;
        peak = 0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 32'h1234_5655);
        idle(FR + 5);
        decode(t0, m_edge);
        chk("t2_frames", dq.size(), 1);
        if (dq.size() >= 1) chk("t2_byte", dq[0], 8'h55);
        chk("t2_peak", peak, 1);

        t0 = m_edge;
        pulse(32'hEE);
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 1'b1, k);
            if (k == 15) begin
                chk("t3_busy_full", out_busy, 1);
                chk("t3_count_full", fifo_count, 16);
            end
            cyc(1'b1, 1'b0, 32'h0);
        end
        n = 0;
        do begin
            cyc(1'b1, 1'b1, 32'h10);
            n++;
        end while (out_busy && n < 200);
        chk("t3_busy_fell", out_busy, 0);
        chk("t3_count_after_pop", fifo_count, 15);
        cyc(1'b1, 1'b1, 32'h10);
        chk("t3_pending_accepted", fifo_count, 16);
        chk("t3_busy_again", out_busy, 1);
        idle(18 * (FR + 1) + 10);
        decode(t0, m_edge);
        chk("t3_frames", dq.size(), 18);
        if (dq.size() == 18) begin
            chk("t3_first", dq[0], 8'hEE);
            for (int k = 0; k < 17; k++) chk($sformatf("t3_order%0d", k), dq[k+1], k);
        end

        t0 = m_edge;
        pulse(32'h11);
        pulse(32'h22);
        chk("t4_count_before", fifo_count, 1);
        n = 0;
        while (m_edge < m_pop + FR && n < 200) begin
            cyc(1'b1, 1'b0, 32'h0);
            n++;
        end
        cyc(1'b1, 1'b1, 32'h33);
        chk("t4_count_same", fifo_count, 1);
        chk("t4_popped", txd, 0);
        idle(3 * (FR + 1) + 10);
        decode(t0, m_edge);
        chk("t4_frames", dq.size(), 3);
        if (dq.size() == 3) begin
            chk("t4_b0", dq[0], 8'h11);
            chk("t4_b1", dq[1], 8'h22);
            chk("t4_b2", dq[2], 8'h33);
        end

        t0 = m_edge;
        pulse(32'h6A);
        pulse(32'hB1);
        pulse(32'hC2);
        pulse(32'hD3);
        n = 0;
        while (m_edge - m_pop < 3 * CPB && n < 200) begin
            cyc(1'b1, 1'b0, 32'h0);
            n++;
        end
        chk("t5_queued", fifo_count, 3);
        cyc(1'b0, 1'b0, 32'h0);
        chk("t5_txd", txd, 1);
        chk("t5_count", fifo_count, 0);
        chk("t5_busy", out_busy, 0);
        t0 = m_edge;
        idle(60);
        decode(t0, m_edge);
        chk("t5_no_frames", dq.size(), 0);

        t0 = m_edge;
        pulse(32'hA5);
        pulse(32'h3C);
        idle(2 * (FR + 1) + 10);
        decode(t0, m_edge);
        chk("t6_frames", dq.size(), 2);
        if (dq.size() == 2) begin
            chk("t6_b0", dq[0], 8'hA5);
            chk("t6_b1", dq[1], 8'h3C);
            chk("t6_gap", ds[1] - (ds[0] + FR), 1);
        end

        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 499) != 0, 1'($urandom_range(0, 1)), $urandom);
        idle(DEPTH * (FR + 1) + 50);
        chk("rand_drained", fifo_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_out_buffer.md
Name: uart_out_buffer

Overview:
Output-side peripheral that sits directly downstream of the core's OUT path. It consumes the core's out_req/out_data, buffers bytes in a FIFO, and drives out_busy back to the core as flow control. Bytes are serialised onto a UART TX line as 8N1 frames, LSB first.

Parameters:
CLK_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range ≥2.
FIFO_DEPTH_LOG, 4, log2 of FIFO depth (default 16 entries).

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
out_req  input  1  core output request; may stay high several consecutive cycles for one OUT instruction
out_data  input  32  core output word; only [7:0] is transmitted
out_busy  output  1  FIFO full; core stalls OUT while high
txd  output  1  UART serial out, idle high
fifo_count  output  FIFO_DEPTH_LOG+1  current FIFO occupancy (debug)

Behaviour:
- Reset: clk edge with rstn=0 sets the following. FIFO empty, fifo_count=0, out_busy=0, txd=1, TX state IDLE, bit/cycle counters 0, req_armed=1. Reset mid-frame aborts the frame: txd=1 on the next cycle and the buffered bytes are lost.
- out_busy is combinational: out_busy = (fifo_count == 2**FIFO_DEPTH_LOG).
- Request acceptance uses the one-shot rule:
  - accept = out_req & req_armed & ~full.
  - On accept, push out_data[7:0] and clear req_armed.
  - req_armed returns to 1 on any cycle with out_req=0.
  - A high out_req seen while full is neither dropped nor pushed. It is accepted on the first cycle the FIFO is not full while out_req is still high.
  - A multi-cycle out_req pulse pushes exactly one byte.
- FIFO:
  - Circular buffer with read and write pointers of width FIFO_DEPTH_LOG; pointers wrap modulo depth.
  - fifo_count is registered.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pop from empty and push to full never occur.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If the FIFO is non-empty, pop the head into an 8-bit shift register and go to START.
  - START: txd=0 for CLK_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for CLK_PER_BIT cycles. Then shift right and increment the index. After bit 7, go to STOP.
  - STOP: txd=1 for CLK_PER_BIT cycles. Then go to IDLE.
- Frame timing:
  - IDLE lasts one cycle when data is waiting, so the inter-frame gap is exactly 1 cycle of txd=1 beyond the stop bit.
  - Frame length is 10*CLK_PER_BIT cycles, start through stop.
- txd is a registered output (no combinational glitches).
- Latency with FIFO empty and TX idle:
  - Accept in cycle t → fifo_count=1 at t+1.
  - Pop in t+1 → fifo_count=0 and txd=0 from t+2.
- Full-boundary timing: when a pop frees a slot, out_busy falls in the cycle after the pop edge. A pending request is accepted in that same cycle, and out_busy rises again the following cycle.
- Cycle counter width: $clog2(CLK_PER_BIT). Bit index width: 3.

Test Plan:
1. Reset, CLK_PER_BIT=4; 1-cycle out_req with out_data=0x00000041 → txd: 4 cycles 0, then bits 1,0,0,0,0,0,1,0 (4 cycles each), then 4 cycles 1. Starts 2 cycles after accept. fifo_count returns to 0.
2. out_req held high for 3 cycles with out_data=0x1234_5655 → exactly one frame, carrying 0x55; fifo_count peaks at 1.
3. With TX stalled by a large CLK_PER_BIT, issue 17 one-cycle requests (bytes 0x00..0x10, separated by out_req=0).
   - out_busy=1 after the 16th accept.
   - The 17th request (held high) is accepted on the first cycle after the pop of 0x00.
   - Output order is 0x00..0x10.
4. Push coinciding with pop (FIFO count 1, TX entering IDLE) → fifo_count stays 1 and the order is preserved.
5. Assert rstn=0 mid-DATA with 3 bytes queued → next cycle txd=1, fifo_count=0, out_busy=0. No further frames until a new request.
6. Back-to-back bytes 0xA5, 0x3C → exactly 1 extra idle-high cycle between the stop bit and the next start bit.
